// File: rtl/stream_error_checker_pkg.sv
// Shared types and helpers for the stream error checker.
// Counters up to 64 bits wide are supported by the saturating adder below.
package stream_error_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Adds two values and clamps the result to the largest w-bit number.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/stream_error_checker_popcount.sv
// Combinational population count built as a balanced binary adder tree.
module stream_error_checker_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             data,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int LEAVES = 1 << $clog2(WIDTH);

  logic [LEAVES-1:0] padded;

  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < WIDTH) begin : g_bit
      assign padded[gi] = data[gi];
    end else begin : g_pad
      assign padded[gi] = 1'b0;
    end
  end

  // Each pass halves the number of partial sums; lower slots are overwritten
  // only after the pair they depend on has been read.
  always_comb begin
    logic [CW-1:0] lvl [LEAVES];
    for (int i = 0; i < LEAVES; i++) begin
      lvl[i] = CW'(padded[i]);
    end
    for (int s = LEAVES / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    count = lvl[0];
  end

endmodule

// File: rtl/stream_error_checker.sv
// Joins a received stream with a reference stream and accumulates word,
// errored-word and errored-bit counts over a controlled measurement window.
module stream_error_checker
  import stream_error_checker_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       S_AXIS_RX_TDATA,
  input  logic                   S_AXIS_RX_TVALID,
  output logic                   S_AXIS_RX_TREADY,
  input  logic [WIDTH-1:0]       S_AXIS_REF_TDATA,
  input  logic                   S_AXIS_REF_TVALID,
  output logic                   S_AXIS_REF_TREADY,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] window_len,
  output logic                   running,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] error_word_count,
  output logic [COUNT_WIDTH-1:0] bit_error_count,
  output logic [COUNT_WIDTH-1:0] first_error_index,
  output logic [WIDTH-1:0]       last_error_mask
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONES = '1;

  function automatic logic [COUNT_WIDTH-1:0] cnt_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [63:0] b);
    return COUNT_WIDTH'(sat_add(64'(a), b, COUNT_WIDTH));
  endfunction

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] tagged_q, tagged_d;
  logic [WIDTH-1:0]       p1_x_q, p1_x_d;
  logic                   p1_tag_q, p1_tag_d;
  logic [PW-1:0]          p2_pop_q, p2_pop_d;
  logic                   p2_nz_q, p2_nz_d;
  logic [WIDTH-1:0]       p2_x_q, p2_x_d;
  logic                   p2_tag_q, p2_tag_d;
  logic [COUNT_WIDTH-1:0] word_q, word_d;
  logic [COUNT_WIDTH-1:0] err_word_q, err_word_d;
  logic [COUNT_WIDTH-1:0] bit_err_q, bit_err_d;
  logic [COUNT_WIDTH-1:0] first_err_q, first_err_d;
  logic [WIDTH-1:0]       mask_q, mask_d;

  logic                   accept;
  logic                   tag_in;
  logic                   flush;
  logic [COUNT_WIDTH-1:0] tag_base;
  logic [PW-1:0]          pop_w;

  stream_error_checker_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data  (p1_x_q),
    .count (pop_w)
  );

  always_comb begin
    accept      = S_AXIS_RX_TVALID & S_AXIS_REF_TVALID;
    state_d     = state_q;
    tagged_d    = tagged_q;
    tag_in      = 1'b0;
    flush       = 1'b0;
    tag_base    = tagged_q;
    word_d      = word_q;
    err_word_d  = err_word_q;
    bit_err_d   = bit_err_q;
    first_err_d = first_err_q;
    mask_d      = mask_q;

    if (clear) begin
      state_d  = IDLE;
      tagged_d = '0;
      flush    = 1'b1;
    end else if (start || state_q == RUN) begin
      // A start restarts the tag total so its own accept is beat number one.
      flush    = start;
      tag_base = start ? '0 : tagged_q;
      tag_in   = accept;
      tagged_d = accept ? cnt_add(tag_base, 64'd1) : tag_base;
      state_d  = RUN;
      if (!start && stop) begin
        state_d = DONE;
      end else if (accept && window_len != '0 && tagged_d == window_len) begin
        state_d = DONE;
      end
    end

    p1_x_d   = S_AXIS_RX_TDATA ^ S_AXIS_REF_TDATA;
    p1_tag_d = tag_in;
    p2_x_d   = p1_x_q;
    p2_pop_d = pop_w;
    p2_nz_d  = |p1_x_q;
    p2_tag_d = p1_tag_q & ~flush;

    // Beats already in flight when counters are cleared are discarded.
    if (flush) begin
      word_d      = '0;
      err_word_d  = '0;
      bit_err_d   = '0;
      first_err_d = CNT_ONES;
      mask_d      = '0;
    end else if (p2_tag_q) begin
      word_d = cnt_add(word_q, 64'd1);
      if (p2_nz_q) begin
        err_word_d = cnt_add(err_word_q, 64'd1);
        bit_err_d  = cnt_add(bit_err_q, 64'(p2_pop_q));
        mask_d     = p2_x_q;
        if (first_err_q == CNT_ONES) begin
          first_err_d = word_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tagged_q    <= '0;
      p1_x_q      <= '0;
      p1_tag_q    <= 1'b0;
      p2_pop_q    <= '0;
      p2_nz_q     <= 1'b0;
      p2_x_q      <= '0;
      p2_tag_q    <= 1'b0;
      word_q      <= '0;
      err_word_q  <= '0;
      bit_err_q   <= '0;
      first_err_q <= CNT_ONES;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      tagged_q    <= tagged_d;
      p1_x_q      <= p1_x_d;
      p1_tag_q    <= p1_tag_d;
      p2_pop_q    <= p2_pop_d;
      p2_nz_q     <= p2_nz_d;
      p2_x_q      <= p2_x_d;
      p2_tag_q    <= p2_tag_d;
      word_q      <= word_d;
      err_word_q  <= err_word_d;
      bit_err_q   <= bit_err_d;
      first_err_q <= first_err_d;
      mask_q      <= mask_d;
    end
  end

  assign S_AXIS_RX_TREADY  = accept;
  assign S_AXIS_REF_TREADY = accept;
  assign running           = (state_q == RUN);
  assign done              = (state_q == DONE) && !p1_tag_q && !p2_tag_q;
  assign word_count        = word_q;
  assign error_word_count  = err_word_q;
  assign bit_error_count   = bit_err_q;
  assign first_error_index = first_err_q;
  assign last_error_mask   = mask_q;

endmodule

// File: tb/tb_stream_error_checker.sv
// Randomized scoreboard bench: a list-based model of counted beats predicts the
// results of each measurement, checked by a monitor when done rises.
module tb_stream_error_checker;

  localparam int W  = 32;
  localparam int CW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  rx_data, ref_data;
  logic          rx_valid, ref_valid, rx_ready, ref_ready;
  logic          start, stop, clear;
  logic [CW-1:0] window_len;
  logic          running, done;
  logic [CW-1:0] word_count, error_word_count, bit_error_count, first_error_index;
  logic [W-1:0]  last_error_mask;

  logic [7:0] s_rxd, s_refd, s_mask;
  logic       s_rxv, s_refv, s_rxr, s_refr, s_start, s_stop, s_clear, s_running, s_done;
  logic [3:0] s_win, s_words, s_errs, s_bits, s_first;

  stream_error_checker #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .S_AXIS_RX_TDATA(rx_data), .S_AXIS_RX_TVALID(rx_valid), .S_AXIS_RX_TREADY(rx_ready),
    .S_AXIS_REF_TDATA(ref_data), .S_AXIS_REF_TVALID(ref_valid), .S_AXIS_REF_TREADY(ref_ready),
    .start(start), .stop(stop), .clear(clear), .window_len(window_len),
    .running(running), .done(done), .word_count(word_count),
    .error_word_count(error_word_count), .bit_error_count(bit_error_count),
    .first_error_index(first_error_index), .last_error_mask(last_error_mask)
  );

  stream_error_checker #(.WIDTH(8), .COUNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset),
    .S_AXIS_RX_TDATA(s_rxd), .S_AXIS_RX_TVALID(s_rxv), .S_AXIS_RX_TREADY(s_rxr),
    .S_AXIS_REF_TDATA(s_refd), .S_AXIS_REF_TVALID(s_refv), .S_AXIS_REF_TREADY(s_refr),
    .start(s_start), .stop(s_stop), .clear(s_clear), .window_len(s_win),
    .running(s_running), .done(s_done), .word_count(s_words),
    .error_word_count(s_errs), .bit_error_count(s_bits),
    .first_error_index(s_first), .last_error_mask(s_mask)
  );

  typedef struct {
    logic [CW-1:0] words;
    logic [CW-1:0] errs;
    logic [CW-1:0] bits;
    logic [CW-1:0] first;
    logic [W-1:0]  mask;
    int            done_cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         last_exp;
  logic [W-1:0] counted[$];
  bit           model_run;
  int           last_acc_cyc;
  int           cyc = 0;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected results are derived purely from the list of XOR patterns counted.
  task automatic push_expect(input int end_cyc);
    exp_t e;
    e.words = CW'(counted.size());
    e.errs  = '0;
    e.bits  = '0;
    e.first = '1;
    e.mask  = '0;
    foreach (counted[i]) begin
      if (counted[i] != '0) begin
        e.errs++;
        e.bits += CW'($countones(counted[i]));
        if (e.first == '1) e.first = CW'(i);
        e.mask = counted[i];
      end
    end
    e.done_cyc = end_cyc + 1;
    if (counted.size() != 0 && last_acc_cyc + 3 > e.done_cyc) e.done_cyc = last_acc_cyc + 3;
    exp_q.push_back(e);
    last_exp = e;
    $display("expect: words=%0d errs=%0d bits=%0d first=%0h mask=%08h done@%0d",
             e.words, e.errs, e.bits, e.first, e.mask, e.done_cyc);
  endtask

  task automatic step(input bit rv, input bit fv, input logic [W-1:0] rd, input logic [W-1:0] fd,
                      input bit st, input bit sp, input bit cl);
    bit acc;
    @(negedge clk);
    check("running", 64'(running), 64'(model_run));
    rx_valid = rv; ref_valid = fv; rx_data = rd; ref_data = fd;
    start = st; stop = sp; clear = cl;
    #1;
    acc = rv && fv;
    check("rx_tready", 64'(rx_ready), 64'(acc));
    check("ref_tready", 64'(ref_ready), 64'(acc));
    if (cl) begin
      model_run = 1'b0;
      counted.delete();
    end else if (st) begin
      model_run = 1'b1;
      counted.delete();
    end
    if (model_run && acc) begin
      counted.push_back(rd ^ fd);
      last_acc_cyc = cyc;
      if (window_len != '0 && CW'(counted.size()) == window_len) begin
        model_run = 1'b0;
        push_expect(cyc);
      end
    end
    if (model_run && sp && !st && !cl) begin
      model_run = 1'b0;
      push_expect(cyc);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'($urandom), $urandom, $urandom, 0, 0, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_words"}, 64'(word_count), 64'd0);
    check({tag, "_errs"}, 64'(error_word_count), 64'd0);
    check({tag, "_bits"}, 64'(bit_error_count), 64'd0);
    check({tag, "_first"}, 64'(first_error_index), 64'({CW{1'b1}}));
  endtask

  // Monitor: every rising edge of done retires one expected measurement.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && done && !prev) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL done_unexpected: actual=done rose required=no pending measurement (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("word_count", 64'(word_count), 64'(e.words));
          check("error_word_count", 64'(error_word_count), 64'(e.errs));
          check("bit_error_count", 64'(bit_error_count), 64'(e.bits));
          check("first_error_index", 64'(first_error_index), 64'(e.first));
          check("last_error_mask", 64'(last_error_mask), 64'(e.mask));
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        end
      end
      prev = done;
    end
  end

  initial begin
    logic [W-1:0] d, e;
    bit rv, fv;
    reset = 1'b1; rx_valid = 0; ref_valid = 0; rx_data = '0; ref_data = '0;
    start = 0; stop = 0; clear = 0; window_len = '0; model_run = 1'b0; last_acc_cyc = 0;
    s_rxd = '0; s_refd = '0; s_rxv = 0; s_refv = 0; s_start = 0; s_stop = 0; s_clear = 0; s_win = '0;
    repeat (3) @(negedge clk);
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mask", 64'(last_error_mask), 64'd0);
    check_cleared("rst");
    reset = 1'b0;

    // Identical streams over a 100-beat window; start beat is counted.
    window_len = CW'(100);
    step(1, 1, 32'hA5A5_0000, 32'hA5A5_0000, 1, 0, 0);
    for (int g = 0; g < 500 && model_run; g++) begin
      d = $urandom; step(1, 1, d, d, 0, 0, 0);
    end
    idle_steps(8);
    check("after_window_done", 64'(done), 64'd1);
    check("after_window_words", 64'(word_count), 64'(last_exp.words));

    // Two-bit error on counted beat 7 of a 20-beat window.
    window_len = CW'(20);
    step(0, 0, '0, '0, 1, 0, 0);
    for (int g = 0; g < 100 && model_run; g++) begin
      d = $urandom;
      e = (counted.size() == 7) ? 32'h0000_0101 : 32'h0;
      step(1, 1, d ^ e, d, 0, 0, 0);
    end
    idle_steps(6);

    // Independent random valid gaps with sparse random errors, 1000 beats.
    window_len = CW'(1000);
    step(0, 0, '0, '0, 1, 0, 0);
    for (int g = 0; g < 6000 && model_run; g++) begin
      rv = ($urandom_range(0, 9) < 7);
      fv = ($urandom_range(0, 9) < 7);
      d = $urandom;
      e = ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      if ($urandom_range(0, 19) == 0) e = e | $urandom;
      step(rv, fv, d ^ e, d, 0, 0, 0);
    end
    idle_steps(6);

    // Unbounded window ended by stop on the tenth accept.
    window_len = '0;
    step(0, 0, '0, '0, 1, 0, 0);
    for (int g = 0; g < 100 && model_run; g++) begin
      d = $urandom;
      e = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      step(1, 1, d ^ e, d, 0, (counted.size() == 9), 0);
    end
    idle_steps(10);
    check("after_stop_done", 64'(done), 64'd1);
    check("after_stop_words", 64'(word_count), 64'd10);

    // Clear with errored beats in the pipeline.
    step(0, 0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin d = $urandom; step(1, 1, ~d, d, 0, 0, 0); end
    step(0, 0, '0, '0, 0, 0, 1);
    step(0, 0, '0, '0, 0, 0, 0);
    check_cleared("clear_next");
    repeat (4) step(0, 0, '0, '0, 0, 0, 0);
    check_cleared("clear_drain");
    check("clear_done", 64'(done), 64'd0);

    // Restart with errored beats in the pipeline, then stop with nothing counted.
    step(0, 0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin d = $urandom; step(1, 1, d ^ 32'h8000_0001, d, 0, 0, 0); end
    step(0, 0, '0, '0, 1, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0);
    check_cleared("restart_next");
    repeat (4) step(0, 0, '0, '0, 0, 0, 0);
    check_cleared("restart_drain");
    step(0, 0, '0, '0, 0, 1, 0);
    idle_steps(6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Narrow counters: 3 errored bits per beat saturate the bit counter.
    @(negedge clk); s_start = 1;
    @(negedge clk); s_start = 0;
    for (int i = 0; i < 10; i++) begin
      s_rxv = 1; s_refv = 1; s_refd = 8'($urandom); s_rxd = s_refd ^ 8'h07;
      @(negedge clk);
    end
    s_rxv = 0; s_refv = 0; s_stop = 1;
    @(negedge clk); s_stop = 0;
    repeat (4) @(negedge clk);
    $display("small run 10: words=%0d errs=%0d bits=%0d first=%0d done=%0b", s_words, s_errs, s_bits, s_first, s_done);
    check("sat10_words", 64'(s_words), 64'd10);
    check("sat10_errs", 64'(s_errs), 64'd10);
    check("sat10_bits", 64'(s_bits), 64'd15);
    check("sat10_first", 64'(s_first), 64'd0);
    check("sat10_mask", 64'(s_mask), 64'h07);
    check("sat10_done", 64'(s_done), 64'd1);

    s_start = 1;
    @(negedge clk); s_start = 0;
    for (int i = 0; i < 20; i++) begin
      s_rxv = 1; s_refv = 1; s_refd = 8'($urandom); s_rxd = s_refd ^ 8'hE0;
      @(negedge clk);
    end
    s_rxv = 0; s_refv = 0; s_stop = 1;
    @(negedge clk); s_stop = 0;
    repeat (4) @(negedge clk);
    $display("small run 20: words=%0d errs=%0d bits=%0d first=%0d done=%0b", s_words, s_errs, s_bits, s_first, s_done);
    check("sat20_words", 64'(s_words), 64'd15);
    check("sat20_errs", 64'(s_errs), 64'd15);
    check("sat20_bits", 64'(s_bits), 64'd15);
    check("sat20_mask", 64'(s_mask), 64'hE0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
